// File: rtl/rle_pkg.sv
// Shared definitions for the RLE run arbiter: field widths, packet framing, FSM states.
// No logic; constants and types only.
// Not applicable (no handshakes in a package).
package rle_pkg;

    // Field widths for the default line geometry (640 pixels, runs up to 12).
    localparam int XW = $clog2(640);
    localparam int CW = $clog2(12);

    // Every packet opens with this tag in the top two bits of its first byte.
    localparam logic [1:0] SYNC_TAG = 2'b10;

    // Bytes per serialised run record.
    localparam int PKT_LEN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rle_rr_picker.sv
// Round-robin first-one finder: nearest set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rle_rr_picker #(
    parameter int NumReq = 3
) (
    input  logic [NumReq-1:0] req,
    input  logic [1:0]        ptr,
    output logic [1:0]        grant,
    output logic              any
);

    logic [2:0] sum;

    // Walk from the farthest candidate down to ptr so the nearest set request is assigned last and wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + 3'(i);
            if (sum >= 3'(NumReq)) begin
                sum = sum - 3'(NumReq);
            end
            if (req[sum[1:0]]) begin
                grant = sum[1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rle_run_arbiter.sv
// Collects run records from per-channel RLE engines and serialises them round-robin as 4-byte packets.
// Latency: record pulse at edge t is captured at t; first packet byte is valid after edge t+1.
// Backpressure: bytes hold while i_tx_ready is low; a full slot drops new records and flags o_overflow.
module rle_run_arbiter
    import rle_pkg::*;
#(
    parameter int NumChannels   = 3,
    parameter int ChannelLength = 640,
    parameter int MaxRunLength  = 12,
    localparam int XBITS = $clog2(ChannelLength),
    localparam int CBITS = $clog2(MaxRunLength)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NumChannels-1:0]         i_run_ready,
    input  logic [8*NumChannels-1:0]       i_run_val,
    input  logic [CBITS*NumChannels-1:0]   i_run_count,
    input  logic [XBITS*NumChannels-1:0]   i_run_start_x,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_valid,
    input  logic                           i_tx_ready,
    input  logic                           i_clr_ovf,
    output logic [NumChannels-1:0]         o_overflow,
    output logic                           o_busy
);

    logic [NumChannels-1:0] slot_full;
    logic [7:0]             slot_val [NumChannels];
    logic [CBITS-1:0]       slot_cnt [NumChannels];
    logic [XBITS-1:0]       slot_x   [NumChannels];

    arb_state_e             state;
    logic [1:0]             byte_idx;
    logic [1:0]             rr_ptr;
    logic [23:0]            tx_rest;

    logic [1:0]             pick_idx;
    logic                   pick_any;
    logic                   last_xfer;
    logic                   grant;
    logic [1:0]             next_ptr;
    logic [NumChannels-1:0] release_vec;
    logic [NumChannels-1:0] take;
    logic [NumChannels-1:0] drop;
    logic [31:0]            grant_pkt;

    rle_rr_picker #(
        .NumReq (NumChannels)
    ) u_picker (
        .req   (slot_full),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    // Decide the grant, which slots release/capture/drop, and the packet for the granted slot.
    always_comb begin
        last_xfer = (state == SEND) && o_tx_valid && i_tx_ready && (byte_idx == 2'(PKT_LEN - 1));
        grant     = pick_any && ((state == IDLE) || last_xfer);
        next_ptr  = (pick_idx == 2'(NumChannels - 1)) ? 2'd0 : pick_idx + 2'd1;
        for (int k = 0; k < NumChannels; k++) begin
            release_vec[k] = grant && (pick_idx == 2'(k));
            take[k]        = i_run_ready[k] && (!slot_full[k] || release_vec[k]);
            drop[k]        = i_run_ready[k] && slot_full[k] && !release_vec[k];
        end
        grant_pkt = {SYNC_TAG, pick_idx, 4'(slot_cnt[pick_idx]),
                     16'(slot_x[pick_idx]), slot_val[pick_idx]};
    end

    // Slot occupancy and the sticky overflow flags; a new drop beats a clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            slot_full  <= '0;
            o_overflow <= '0;
        end else begin
            slot_full  <= (slot_full & ~release_vec) | take;
            o_overflow <= (i_clr_ovf ? '0 : o_overflow) | drop;
        end
    end

    // Record payload registers; contents only matter while the slot is full.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NumChannels; k++) begin
            if (take[k]) begin
                slot_val[k] <= i_run_val[8*k +: 8];
                slot_cnt[k] <= i_run_count[CBITS*k +: CBITS];
                slot_x[k]   <= i_run_start_x[XBITS*k +: XBITS];
            end
        end
    end

    // Serialiser FSM: grant loads all four bytes, each accepted byte shifts the next one out.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            byte_idx   <= '0;
            rr_ptr     <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            tx_rest    <= '0;
        end else if (grant) begin
            state      <= SEND;
            byte_idx   <= '0;
            rr_ptr     <= next_ptr;
            o_tx_valid <= 1'b1;
            o_tx_data  <= grant_pkt[31:24];
            tx_rest    <= grant_pkt[23:0];
        end else if ((state == SEND) && o_tx_valid && i_tx_ready) begin
            if (last_xfer) begin
                state      <= IDLE;
                byte_idx   <= '0;
                o_tx_valid <= 1'b0;
            end else begin
                byte_idx  <= byte_idx + 2'd1;
                o_tx_data <= tx_rest[23:16];
                tx_rest   <= {tx_rest[15:0], 8'h00};
            end
        end
    end

    assign o_busy = (state != IDLE) || (|slot_full);

endmodule

// File: tb/tb_rle_run_arbiter.sv
// Bench for rle_run_arbiter: table vectors, directed corner sequences and a random run
// checked every cycle against a byte-queue reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or 1 unit after the rising edge.
module tb_rle_run_arbiter;
    import rle_pkg::*;

    localparam int N = 3;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [N-1:0]    run_ready = '0;
    logic [8*N-1:0]  run_val = '0;
    logic [CW*N-1:0] run_count = '0;
    logic [XW*N-1:0] run_x = '0;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic            clr = 1'b0;
    logic [N-1:0]    ovf;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 CLK = ~CLK;

    rle_run_arbiter #(
        .NumChannels   (N),
        .ChannelLength (640),
        .MaxRunLength  (12)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_run_ready   (run_ready),
        .i_run_val     (run_val),
        .i_run_count   (run_count),
        .i_run_start_x (run_x),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready),
        .i_clr_ovf     (clr),
        .o_overflow    (ovf),
        .o_busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rec(input int k, input int v, input int c, input int x);
        run_val[8*k +: 8]     = 8'(v);
        run_count[CW*k +: CW] = CW'(c);
        run_x[XW*k +: XW]     = XW'(x);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        run_ready = m;
        step();
        run_ready = '0;
    endtask

    // ---------------- reference model: pending records plus a queue of bytes still to send
    logic [7:0] mq[$];
    logic [N-1:0] m_full = '0;
    logic [N-1:0] m_ovf = '0;
    logic [N-1:0] m_drop;
    int m_ptr = 0;
    int m_val[N];
    int m_cnt[N];
    int m_x[N];
    int g, kk;

    task automatic model_edge();
        if (!RST) begin
            mq.delete();
            m_full = '0;
            m_ovf  = '0;
            m_ptr  = 0;
        end else begin
            if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
            if (mq.size() == 0 && m_full != '0) begin
                g = -1;
                for (int i = 0; i < N; i++) begin
                    kk = (m_ptr + i) % N;
                    if (g < 0 && m_full[kk]) g = kk;
                end
                mq.push_back(8'(128 + g * 16 + m_cnt[g]));
                mq.push_back(8'(m_x[g] / 256));
                mq.push_back(8'(m_x[g] % 256));
                mq.push_back(8'(m_val[g]));
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end
            m_drop = '0;
            for (int i = 0; i < N; i++) begin
                if (run_ready[i]) begin
                    if (m_full[i]) m_drop[i] = 1'b1;
                    else begin
                        m_full[i] = 1'b1;
                        m_val[i]  = int'(run_val[8*i +: 8]);
                        m_cnt[i]  = int'(run_count[CW*i +: CW]);
                        m_x[i]    = int'(run_x[XW*i +: XW]);
                    end
                end
            end
            m_ovf = (clr ? '0 : m_ovf) | m_drop;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_edge();
    end

    // Per-cycle comparison against the model, plus a log of every accepted byte.
    logic [7:0] mon[$];
    initial forever begin
        @(negedge CLK);
        if (tx_valid && tx_ready) mon.push_back(tx_data);
        if (chk_en) begin
            chk("model_valid", 32'(tx_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("model_data", 32'(tx_data), 32'(mq[0]));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
            chk("model_busy", 32'(busy), 32'((mq.size() != 0) || (m_full != '0)));
        end
    end

    task automatic wait_bytes(input int n);
        for (int c = 0; c < 300 && mon.size() < n; c++) step();
        chk("byte_count", 32'(mon.size()), 32'(n));
    endtask

    task automatic chk_seq(input string nm, input logic [7:0] exp [16], input int n);
        for (int i = 0; i < n; i++) begin
            if (i < mon.size()) chk(nm, 32'(mon[i]), 32'(exp[i]));
        end
    endtask

    typedef struct {
        logic [N-1:0] rdy;
        logic         txr;
        logic         clr;
        logic         vld;
        logic [7:0]   dat;
        logic [N-1:0] ovf;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] r, input logic t, input logic v, input logic [7:0] d);
        vec_t x;
        x.rdy = r; x.txr = t; x.clr = 1'b0; x.vld = v; x.dat = d; x.ovf = '0;
        return x;
    endfunction

    vec_t tbl[17];
    logic [7:0] e16[16];

    initial begin
        // single record with ready high, then the same record with a 5-cycle stall on B1
        tbl[0]  = mk(3'b010, 1, 0, 8'h00);
        tbl[1]  = mk(3'b000, 1, 1, 8'h97);
        tbl[2]  = mk(3'b000, 1, 1, 8'h01);
        tbl[3]  = mk(3'b000, 1, 1, 8'h2C);
        tbl[4]  = mk(3'b000, 1, 1, 8'h5A);
        tbl[5]  = mk(3'b000, 1, 0, 8'h00);
        tbl[6]  = mk(3'b010, 1, 0, 8'h00);
        tbl[7]  = mk(3'b000, 1, 1, 8'h97);
        tbl[8]  = mk(3'b000, 1, 1, 8'h01);
        for (int i = 9; i < 14; i++) tbl[i] = mk(3'b000, 0, 1, 8'h01);
        tbl[14] = mk(3'b000, 1, 1, 8'h2C);
        tbl[15] = mk(3'b000, 1, 1, 8'h5A);
        tbl[16] = mk(3'b000, 1, 0, 8'h00);

        RST = 1'b0;
        repeat (3) step();
        chk("reset_valid", 32'(tx_valid), 32'd0);
        chk("reset_data", 32'(tx_data), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        RST = 1'b1;
        chk_en = 1'b1;
        step();

        // fairness: all three at once, ch0 again during its own packet
        tx_ready = 1'b1;
        mon.delete();
        set_rec(0, 'h11, 1, 'h001);
        set_rec(1, 'h22, 2, 'h102);
        set_rec(2, 'h33, 3, 'h203);
        pulse(3'b111);
        step();
        chk("fair_first_valid", 32'(tx_valid), 32'd1);
        set_rec(0, 'h44, 4, 639);
        pulse(3'b001);
        repeat (15) @(negedge CLK);
        #1;
        chk("fair_no_gap_count", 32'(mon.size()), 32'd16);
        e16 = '{8'h81, 8'h00, 8'h01, 8'h11, 8'h92, 8'h01, 8'h02, 8'h22,
                8'hA3, 8'h02, 8'h03, 8'h33, 8'h84, 8'h02, 8'h7F, 8'h44};
        chk_seq("fair_byte", e16, 16);
        repeat (3) step();

        // table-driven single record and backpressure
        set_rec(1, 'h5A, 7, 300);
        for (int i = 0; i < 17; i++) begin
            run_ready = tbl[i].rdy;
            tx_ready  = tbl[i].txr;
            clr       = tbl[i].clr;
            step();
            chk("tbl_valid", 32'(tx_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk("tbl_data", 32'(tx_data), 32'(tbl[i].dat));
            chk("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
        end
        run_ready = '0;

        // overflow on ch2 while the link is stalled
        tx_ready = 1'b0;
        set_rec(2, 'h3C, 1, 5);
        pulse(3'b100);
        step();
        set_rec(2, 'hB7, 9, 'h1FF);
        pulse(3'b100);
        set_rec(2, 'hEE, 2, 'h0AA);
        pulse(3'b100);
        set_rec(2, 'hDD, 3, 'h055);
        pulse(3'b100);
        chk("ovf_set", 32'(ovf), 32'b100);
        chk("ovf_hold_valid", 32'(tx_valid), 32'd1);
        chk("ovf_hold_data", 32'(tx_data), 32'hA1);
        mon.delete();
        tx_ready = 1'b1;
        wait_bytes(8);
        e16 = '{8'hA1, 8'h00, 8'h05, 8'h3C, 8'hA9, 8'h01, 8'hFF, 8'hB7,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("ovf_byte", e16, 8);
        chk("ovf_sticky", 32'(ovf), 32'b100);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        repeat (2) step();

        // capture into ch0 on the very edge its slot is granted
        mon.delete();
        set_rec(0, 'h01, 12, 0);
        pulse(3'b001);
        set_rec(0, 'hFE, 5, 639);
        pulse(3'b001);
        wait_bytes(8);
        e16 = '{8'h8C, 8'h00, 8'h00, 8'h01, 8'h85, 8'h02, 8'h7F, 8'hFE,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("coll_byte", e16, 8);
        repeat (2) step();

        // reset in the middle of a packet with slots full and overflow set
        tx_ready = 1'b0;
        set_rec(0, 'h10, 1, 10);
        set_rec(1, 'h20, 2, 20);
        set_rec(2, 'h30, 3, 30);
        run_ready = 3'b111;
        step();
        step();
        run_ready = '0;
        tx_ready = 1'b1;
        step();
        step();
        RST = 1'b0;
        step();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        RST = 1'b1;
        step();
        mon.delete();
        set_rec(0, 'h5A, 7, 300);
        set_rec(2, 'hC3, 0, 1);
        pulse(3'b101);
        wait_bytes(8);
        e16 = '{8'h87, 8'h01, 8'h2C, 8'h5A, 8'hA0, 8'h00, 8'h01, 8'hC3,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("rst_after_byte", e16, 8);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                run_ready[k] = ($urandom_range(0, 3) == 0);
                set_rec(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 639)));
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            step();
        end
        run_ready = '0;
        clr = 1'b0;
        tx_ready = 1'b1;
        repeat (40) step();
        chk("drain_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
